// File: rtl/seg_arb_pkg.sv
// ==== seg_arb_pkg: shared types and constants for the display arbiter ==== Rev 1.0
`default_nettype none

package seg_arb_pkg;

  localparam int DIGITS = 4;
  localparam int NIB_W  = 4;
  localparam int WORD_W = DIGITS * NIB_W;

  typedef logic [WORD_W-1:0] digit_word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_ERR  = 2'd2
  } seg_state_e;

endpackage

`default_nettype wire

// File: rtl/seg_display_arbiter_rr_pick.sv
// ==== rr_pick: combinational round-robin picker, scans from ptr+1 modulo NREQ ==== Rev 1.0
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             found_o
);

  always_comb begin
    gnt_o   = '0;
    found_o = 1'b0;
    // Outer loop walks priority order, inner loop keeps every bit select constant.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found_o && req_i[i] && (i == (int'(ptr_i) + 1 + k) % NREQ)) begin
          gnt_o[i] = 1'b1;
          found_o  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_arbiter.sv
// ==== seg_display_arbiter: round-robin sharing of the 4-digit display, minimum hold, error pre-emption ====
// Optional macro SEG_ARB_BLINK_EN blinks the error code at HOLD_CYCLES/2. Rev 1.0
`default_nettype none

module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*WORD_W-1:0]   data_i,
  input  logic [NIB_W-1:0]         err_code_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [NIB_W-1:0]         num0_o,
  output logic [NIB_W-1:0]         num1_o,
  output logic [NIB_W-1:0]         num2_o,
  output logic [NIB_W-1:0]         num3_o,
  output logic [NIB_W-1:0]         error_o,
  output logic                     busy_o
);

  localparam int               PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NREQ - 1);

  seg_state_e        state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  digit_word_t       num_q, num_d;
  logic [NIB_W-1:0]  error_q, error_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   pick_gnt;
  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx;
  digit_word_t       pick_word;
  digit_word_t       cur_word;
  logic              take;
  logic              err_show;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .found_o (pick_found)
  );

  always_comb begin
    pick_idx  = '0;
    pick_word = '0;
    cur_word  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PTR_W'(i);
        pick_word = data_i[i*WORD_W +: WORD_W];
      end
      if (grant_q[i]) cur_word = data_i[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (err_code_i != '0) begin
          state_d = S_ERR;
          grant_d = '0;
        end else if (pick_found) begin
          take = 1'b1;
        end
      end
      S_SHOW: begin
        if (err_code_i != '0) begin
          state_d = S_ERR;
          grant_d = '0;
        end else if ((grant_q & req_i) == '0) begin
          // Owner released the display: hand it over at once, hold or not.
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (cnt_q == '0) begin
          if ((req_i & ~grant_q) != '0) take = 1'b1;
          else                          num_d = cur_word;
        end else begin
          cnt_d = cnt_q - 1'b1;
          num_d = cur_word;
        end
      end
      S_ERR: begin
        grant_d = '0;
        if (err_code_i == '0) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    if (take) begin
      state_d = S_SHOW;
      grant_d = pick_gnt;
      ptr_d   = pick_idx;
      cnt_d   = HOLD_LOAD;
      num_d   = pick_word;
    end
    busy_d  = (state_d != S_IDLE);
    error_d = (state_d == S_ERR && err_show) ? err_code_i : '0;
  end

`ifdef SEG_ARB_BLINK_EN
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HOLD_CYCLES / 2 - 1);

  logic             phase_q, phase_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;

  always_comb begin
    phase_d  = phase_q;
    ph_cnt_d = ph_cnt_q;
    if (state_d == S_ERR && state_q != S_ERR) begin
      phase_d  = 1'b1;
      ph_cnt_d = HALF_LOAD;
    end else if (state_d == S_ERR) begin
      if (ph_cnt_q == '0) begin
        phase_d  = ~phase_q;
        ph_cnt_d = HALF_LOAD;
      end else begin
        ph_cnt_d = ph_cnt_q - 1'b1;
      end
    end
    err_show = phase_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= 1'b0;
      ph_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      ph_cnt_q <= ph_cnt_d;
    end
  end
`else
  assign err_show = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      num_q   <= '0;
      error_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign num0_o  = num_q[0*NIB_W +: NIB_W];
  assign num1_o  = num_q[1*NIB_W +: NIB_W];
  assign num2_o  = num_q[2*NIB_W +: NIB_W];
  assign num3_o  = num_q[3*NIB_W +: NIB_W];
  assign error_o = error_q;
  assign busy_o  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ==== tb_seg_display_arbiter: directed + randomized checks against a cycle-level reference model ==== Rev 1.0
`default_nettype none

module tb_seg_display_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef SEG_ARB_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_SHOW = 1;
  localparam int M_ERR  = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] dw [4];
  logic [63:0] data;
  logic [3:0]  err_code;
  logic [3:0]  grant;
  logic [3:0]  n0, n1, n2, n3;
  logic [3:0]  error;
  logic        busy;
  logic [15:0] word;

  int tests;
  int fails;

  // Reference model state
  int          m_mode, m_g, m_ptr, m_shown, m_ecnt;
  logic [15:0] m_num;
  logic [3:0]  m_err;

  assign data = {dw[3], dw[2], dw[1], dw[0]};
  assign word = {n3, n2, n1, n0};

  seg_display_arbiter #(
    .NREQ        (N),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .data_i     (data),
    .err_code_i (err_code),
    .grant_o    (grant),
    .num0_o     (n0),
    .num1_o     (n1),
    .num2_o     (n2),
    .num3_o     (n3),
    .error_o    (error),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit reqbit(input logic [3:0] r, input int i);
    return ((r >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int m_pick(input int p, input logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      if (reqbit(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_g >= 0) ? 4'(1 << m_g) : 4'd0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_g = -1; m_ptr = N - 1; m_shown = 0; m_ecnt = 0;
    m_num = '0; m_err = '0;
  endtask

  task automatic model_take(input int i);
    m_mode = M_SHOW; m_g = i; m_ptr = i; m_shown = 1; m_num = dw[i];
  endtask

  // One clock of behaviour from the rules: error first, then owner release, then hold expiry.
  task automatic model_step();
    int np;
    np = m_pick(m_ptr, req);
    if (err_code != 4'd0) begin
      m_ecnt = (m_mode == M_ERR) ? m_ecnt + 1 : 0;
      m_mode = M_ERR;
      m_g    = -1;
      m_err  = (!BLINK || ((m_ecnt / (HOLD / 2)) % 2 == 0)) ? err_code : 4'd0;
    end else if (m_mode == M_ERR) begin
      m_mode = M_IDLE;
      m_err  = 4'd0;
    end else if (m_mode == M_IDLE) begin
      if (np >= 0) model_take(np);
    end else if (!reqbit(req, m_g)) begin
      if (np >= 0) model_take(np);
      else begin m_mode = M_IDLE; m_g = -1; end
    end else if (m_shown >= HOLD && (req & ~exp_grant()) != 4'd0) begin
      model_take(np);
    end else begin
      m_shown++;
      m_num = dw[m_g];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; err_code = '0;
    for (int i = 0; i < 4; i++) dw[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({grant, word, error, busy} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: got grant=%b num=%h error=%h busy=%b, want all zero", grant, word, error, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    dw[0] = 16'h1234; req = 4'b0001;
    tick();
    tests++;
    if (grant !== 4'b0001 || word !== 16'h1234 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: got grant=%b num=%h busy=%b, want 0001 1234 1", grant, word, busy);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (grant !== 4'b0000 || busy !== 1'b0 || word !== 16'h1234) begin
      fails++;
      $display("FAIL single_idle: got grant=%b busy=%b num=%h, want 0000 0 1234", grant, busy, word);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    dw[2] = 16'h0C0C; req = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      tick();
      want = ((k / HOLD) % 2 == 0) ? 4'b0100 : 4'b0001;
      tests++;
      if (grant !== want) begin
        fails++;
        $display("FAIL rotation_k%0d: got grant=%b, want %b", k, grant, want);
      end
    end
    tests++;
    if (word !== 16'h0C0C) begin
      fails++;
      $display("FAIL rotation_num: got num=%h, want 0c0c", word);
    end
  endtask

  task automatic test_drop();
    req = 4'b0001;
    tick();
    tests++;
    if (grant !== 4'b0001 || word !== 16'h1234) begin
      fails++;
      $display("FAIL drop_regrant: got grant=%b num=%h, want 0001 1234", grant, word);
    end
  endtask

  task automatic test_error();
    dw[0] = 16'h5A5A; dw[1] = 16'h0042; req = 4'b0011;
    tick();
    tests++;
    if (grant !== 4'b0001 || word !== 16'h5A5A) begin
      fails++;
      $display("FAIL error_pre_hold: got grant=%b num=%h, want 0001 5a5a", grant, word);
    end
    err_code = 4'h3; dw[0] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++;
      if (grant !== 4'b0000 || error !== 4'h3 || busy !== 1'b1 || word !== 16'h5A5A) begin
        fails++;
        $display("FAIL error_active_%0d: got grant=%b error=%h busy=%b num=%h, want 0000 3 1 5a5a", k, grant, error, busy, word);
      end
    end
    err_code = 4'h0;
    tick();
    tests++;
    if (grant !== 4'b0000 || error !== 4'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL error_clear: got grant=%b error=%h busy=%b, want 0000 0 0", grant, error, busy);
    end
    tick();
    tests++;
    if (grant !== 4'b0010 || word !== 16'h0042) begin
      fails++;
      $display("FAIL error_resume: got grant=%b num=%h, want 0010 0042", grant, word);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({grant, word, error, busy} !== 25'd0) begin
      fails++;
      $display("FAIL async_reset: got grant=%b num=%h error=%h busy=%b, want all zero", grant, word, error, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1001;
    tick();
    tests++;
    if (grant !== 4'b0001 || word !== 16'hFFFF) begin
      fails++;
      $display("FAIL reset_first_winner: got grant=%b num=%h, want 0001 ffff", grant, word);
    end
  endtask

`ifdef SEG_ARB_BLINK_EN
  task automatic test_blink();
    logic [3:0] seq [6];
    seq = '{4'h5, 4'h5, 4'h0, 4'h0, 4'h5, 4'h5};
    err_code = 4'h5;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if (error !== seq[k]) begin
        fails++;
        $display("FAIL blink_k%0d: got error=%h, want %h", k, error, seq[k]);
      end
    end
    err_code = 4'h0;
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) dw[i] = 16'($urandom);
      if (err_code == 4'd0) begin
        if ($urandom_range(0, 24) == 0) err_code = 4'($urandom_range(1, 15));
      end else if ($urandom_range(0, 5) == 0) begin
        err_code = 4'd0;
      end
      tick();
      tests++;
      if (grant !== exp_grant() || word !== m_num || error !== m_err || busy !== (m_mode != M_IDLE)) begin
        fails++;
        $display("FAIL random_c%0d: got grant=%b num=%h error=%h busy=%b, want %b %h %h %b",
                 c, grant, word, error, busy, exp_grant(), m_num, m_err, (m_mode != M_IDLE));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_error();
    test_async_reset();
`ifdef SEG_ARB_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
